// File: rtl/guess_pkg.sv
// guess_pkg: shared types for the guess-the-number game controller.
//   state_t   - controller state encoding (also driven on the 'state' port)
//   bcd_t     - one BCD digit
//   sm_to_int - signed-magnitude two-digit BCD to a signed binary value
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;

  // Only meaningful for valid digits (0..9); -0 and +0 both give 0.
  function automatic logic signed [7:0] sm_to_int(input logic neg,
                                                 input bcd_t tens,
                                                 input bcd_t ones);
    logic [7:0] mag;
    mag = {4'b0, tens} * 8'd10 + {4'b0, ones};
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer, debounce counter and press-pulse
// generator for one active-low pushbutton.
//   clk, rst_n - clock, asynchronous active-low reset
//   btn_n      - raw active-low button, asynchronous to clk
//   press      - one-cycle pulse per accepted press
// A press is accepted after DEBOUNCE_CYCLES consecutive low synchronized
// samples; the detector then re-arms only after DEBOUNCE_CYCLES consecutive
// high samples, so one press gives exactly one pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;

  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    // armed: counting low samples toward a press; disarmed: counting high
    // samples toward release. Any sample of the other level restarts.
    if (armed_q == sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      armed_d = ~armed_q;
      press_d = armed_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/guess_game_sequencer.sv
// guess_game_sequencer: central controller for the guess-the-number game.
// Debounces Start/Guess, latches the random target, scores guesses,
// keeps a BCD guess count and produces hint/result signals.
// Ports:
//   Clock, Reset (async active-low)
//   Start_button, Guess_button - raw active-low pushbuttons
//   switch[8:0]  - guess: [8] sign, [7:4] tens, [3:0] ones ([9] ignored)
//   rdm_*        - free-running random target
//   state        - controller state (guess_pkg::state_t encoding)
//   tgt_*        - latched target (-0 stored as +0)
//   count_*      - BCD count of valid guesses, saturating at 99
//   hint_high/hint_low - last valid guess below/above target
//   invalid      - last guess had a digit above 9
// Build option: define GUESS_LIMIT_EN to end the game in LOSE once
// MAX_GUESSES valid non-matching guesses have been taken.
module guess_game_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_GUESSES     = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_button,
  input  logic       Guess_button,
  input  logic [9:0] switch,
  input  logic       rdm_neg,
  input  logic [3:0] rdm_tens,
  input  logic [3:0] rdm_ones,
  output logic [2:0] state,
  output logic       tgt_neg,
  output logic [3:0] tgt_tens,
  output logic [3:0] tgt_ones,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones,
  output logic       hint_high,
  output logic       hint_low,
  output logic       invalid
);
  import guess_pkg::*;

  if (MAX_GUESSES < 1 || MAX_GUESSES > 99) begin : g_bad_max_guesses
    $error("MAX_GUESSES must be in 1..99");
  end

  logic start_p, guess_p;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk   (Clock),
    .rst_n (Reset),
    .btn_n (Start_button),
    .press (start_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_guess_db (
    .clk   (Clock),
    .rst_n (Reset),
    .btn_n (Guess_button),
    .press (guess_p)
  );

  state_t state_q, state_d;
  logic   tgt_neg_q, tgt_neg_d;
  bcd_t   tgt_tens_q, tgt_tens_d;
  bcd_t   tgt_ones_q, tgt_ones_d;
  logic   g_neg_q, g_neg_d;
  bcd_t   g_tens_q, g_tens_d;
  bcd_t   g_ones_q, g_ones_d;
  bcd_t   cnt_tens_q, cnt_tens_d;
  bcd_t   cnt_ones_q, cnt_ones_d;
  logic   hint_high_q, hint_high_d;
  logic   hint_low_q, hint_low_d;
  logic   invalid_q, invalid_d;

  // Scoring of the registered guess
  logic              guess_bad, guess_eq, guess_lt, limit_hit;
  logic signed [7:0] guess_val, tgt_val;
  bcd_t              inc_tens, inc_ones;

  always_comb begin
    guess_bad = (g_tens_q > BCD_NINE) || (g_ones_q > BCD_NINE);
    guess_val = sm_to_int(g_neg_q, g_tens_q, g_ones_q);
    tgt_val   = sm_to_int(tgt_neg_q, tgt_tens_q, tgt_ones_q);
    guess_eq  = (guess_val == tgt_val);
    guess_lt  = (guess_val < tgt_val);
  end

  // BCD ripple increment, saturating at 99
  always_comb begin
    inc_tens = cnt_tens_q;
    inc_ones = cnt_ones_q;
    if (!(cnt_tens_q == BCD_NINE && cnt_ones_q == BCD_NINE)) begin
      if (cnt_ones_q == BCD_NINE) begin
        inc_ones = '0;
        inc_tens = cnt_tens_q + 4'd1;
      end else begin
        inc_ones = cnt_ones_q + 4'd1;
      end
    end
  end

`ifdef GUESS_LIMIT_EN
  always_comb begin
    limit_hit = ((int'(inc_tens) * 10 + int'(inc_ones)) == int'(MAX_GUESSES));
  end
`else
  always_comb begin
    limit_hit = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start has priority over guess in PLAY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WIN, LOSE: if (start_p) state_d = ARM;
      ARM:             state_d = PLAY;
      PLAY: begin
        if (start_p)      state_d = ARM;
        else if (guess_p) state_d = CHECK;
      end
      CHECK: begin
        if (guess_bad)      state_d = PLAY;
        else if (guess_eq)  state_d = WIN;
        else if (limit_hit) state_d = LOSE;
        else                state_d = PLAY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates driven by the current state
  always_comb begin
    tgt_neg_d   = tgt_neg_q;
    tgt_tens_d  = tgt_tens_q;
    tgt_ones_d  = tgt_ones_q;
    g_neg_d     = g_neg_q;
    g_tens_d    = g_tens_q;
    g_ones_d    = g_ones_q;
    cnt_tens_d  = cnt_tens_q;
    cnt_ones_d  = cnt_ones_q;
    hint_high_d = hint_high_q;
    hint_low_d  = hint_low_q;
    invalid_d   = invalid_q;
    unique case (state_q)
      ARM: begin
        tgt_neg_d   = rdm_neg && (rdm_tens != '0 || rdm_ones != '0);
        tgt_tens_d  = rdm_tens;
        tgt_ones_d  = rdm_ones;
        cnt_tens_d  = '0;
        cnt_ones_d  = '0;
        hint_high_d = 1'b0;
        hint_low_d  = 1'b0;
        invalid_d   = 1'b0;
      end
      PLAY: begin
        if (guess_p && !start_p) begin
          g_neg_d  = switch[8];
          g_tens_d = switch[7:4];
          g_ones_d = switch[3:0];
        end
      end
      CHECK: begin
        if (guess_bad) begin
          invalid_d = 1'b1;
        end else begin
          invalid_d   = 1'b0;
          cnt_tens_d  = inc_tens;
          cnt_ones_d  = inc_ones;
          hint_high_d = !guess_eq && guess_lt;
          hint_low_d  = !guess_eq && !guess_lt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tgt_neg_q   <= 1'b0;
      tgt_tens_q  <= '0;
      tgt_ones_q  <= '0;
      g_neg_q     <= 1'b0;
      g_tens_q    <= '0;
      g_ones_q    <= '0;
      cnt_tens_q  <= '0;
      cnt_ones_q  <= '0;
      hint_high_q <= 1'b0;
      hint_low_q  <= 1'b0;
      invalid_q   <= 1'b0;
    end else begin
      tgt_neg_q   <= tgt_neg_d;
      tgt_tens_q  <= tgt_tens_d;
      tgt_ones_q  <= tgt_ones_d;
      g_neg_q     <= g_neg_d;
      g_tens_q    <= g_tens_d;
      g_ones_q    <= g_ones_d;
      cnt_tens_q  <= cnt_tens_d;
      cnt_ones_q  <= cnt_ones_d;
      hint_high_q <= hint_high_d;
      hint_low_q  <= hint_low_d;
      invalid_q   <= invalid_d;
    end
  end

  assign state      = state_q;
  assign tgt_neg    = tgt_neg_q;
  assign tgt_tens   = tgt_tens_q;
  assign tgt_ones   = tgt_ones_q;
  assign count_tens = cnt_tens_q;
  assign count_ones = cnt_ones_q;
  assign hint_high  = hint_high_q;
  assign hint_low   = hint_low_q;
  assign invalid    = invalid_q;

endmodule

// File: tb/tb_guess_game_sequencer.sv
`timescale 1ns/1ps
module tb_guess_game_sequencer;

  localparam int unsigned DB   = 4;
  localparam int unsigned MAXG = 3;
  localparam int S_IDLE = 0, S_ARM = 1, S_PLAY = 2, S_CHECK = 3, S_WIN = 4, S_LOSE = 5;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start_button, Guess_button;
  logic [9:0] switch;
  logic       rdm_neg;
  logic [3:0] rdm_tens, rdm_ones;
  logic [2:0] state;
  logic       tgt_neg;
  logic [3:0] tgt_tens, tgt_ones, count_tens, count_ones;
  logic       hint_high, hint_low, invalid;

  always #5 Clock = ~Clock;

  guess_game_sequencer #(.DEBOUNCE_CYCLES(DB), .MAX_GUESSES(MAXG)) dut (
    .Clock(Clock), .Reset(Reset), .Start_button(Start_button), .Guess_button(Guess_button),
    .switch(switch), .rdm_neg(rdm_neg), .rdm_tens(rdm_tens), .rdm_ones(rdm_ones),
    .state(state), .tgt_neg(tgt_neg), .tgt_tens(tgt_tens), .tgt_ones(tgt_ones),
    .count_tens(count_tens), .count_ones(count_ones),
    .hint_high(hint_high), .hint_low(hint_low), .invalid(invalid)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: target and count as plain signed/unsigned integers
  int m_state, m_tgt, m_count;
  bit m_hh, m_hl, m_inv;

  function automatic void model_start(bit neg, int tens, int ones);
    m_tgt   = neg ? -(tens * 10 + ones) : (tens * 10 + ones);
    m_count = 0;
    m_hh = 0; m_hl = 0; m_inv = 0;
    m_state = S_PLAY;
  endfunction

  function automatic void model_guess(bit neg, int tens, int ones);
    int g;
    if (tens > 9 || ones > 9) begin
      m_inv = 1;
      m_state = S_PLAY;
      return;
    end
    m_inv = 0;
    m_count = (m_count < 99) ? m_count + 1 : 99;
    g = neg ? -(tens * 10 + ones) : (tens * 10 + ones);
    if (g == m_tgt) begin
      m_hh = 0; m_hl = 0;
      m_state = S_WIN;
    end else begin
      m_hh = (g < m_tgt);
      m_hl = (g > m_tgt);
      m_state = S_PLAY;
`ifdef GUESS_LIMIT_EN
      if (m_count == MAXG) m_state = S_LOSE;
`endif
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_state(input int target, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      if (int'(state) == target) break;
      tick();
    end
    chk(name, int'(state), target);
  endtask

  task automatic check_model(input string name);
    int mag;
    mag = (m_tgt < 0) ? -m_tgt : m_tgt;
    chk({name, ".state"}, int'(state), m_state);
    chk({name, ".count_tens"}, int'(count_tens), m_count / 10);
    chk({name, ".count_ones"}, int'(count_ones), m_count % 10);
    chk({name, ".hint_high"}, int'(hint_high), int'(m_hh));
    chk({name, ".hint_low"}, int'(hint_low), int'(m_hl));
    chk({name, ".invalid"}, int'(invalid), int'(m_inv));
    chk({name, ".tgt_neg"}, int'(tgt_neg), (m_tgt < 0) ? 1 : 0);
    chk({name, ".tgt_tens"}, int'(tgt_tens), mag / 10);
    chk({name, ".tgt_ones"}, int'(tgt_ones), mag % 10);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, ".state"}, int'(state), S_IDLE);
    chk({name, ".tgt"}, int'({tgt_neg, tgt_tens, tgt_ones}), 0);
    chk({name, ".count"}, int'({count_tens, count_ones}), 0);
    chk({name, ".hints"}, int'({hint_high, hint_low, invalid}), 0);
  endtask

  task automatic do_start(input bit neg, input int tens, input int ones, input string name);
    rdm_neg = neg; rdm_tens = 4'(tens); rdm_ones = 4'(ones);
    Start_button = 1'b0;
    wait_state(S_ARM, 20, {name, ".arm"});
    tick();
    model_start(neg, tens, ones);
    check_model(name);
    repeat (2) tick();
    Start_button = 1'b1;
    repeat (10) tick();
  endtask

  task automatic do_guess(input logic [9:0] sw, input string name);
    switch = sw;
    Guess_button = 1'b0;
    wait_state(S_CHECK, 20, {name, ".check"});
    switch = 10'($urandom);  // must not affect the captured guess
    tick();
    model_guess(sw[8], int'(sw[7:4]), int'(sw[3:0]));
    check_model(name);
    repeat (3) tick();
    Guess_button = 1'b1;
    repeat (10) tick();
    chk({name, ".hold"}, int'(state), m_state);
  endtask

  typedef struct {
    logic [9:0] sw;
    int         exp_state;
    logic       hh, hl, inv;
    int         exp_count;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{sw: 10'b0_0_0000_0101, exp_state: S_PLAY, hh: 1'b0, hl: 1'b1, inv: 1'b0, exp_count: 1}; // +05
    vecs[1] = '{sw: 10'b1_1_0101_0000, exp_state: S_PLAY, hh: 1'b1, hl: 1'b0, inv: 1'b0, exp_count: 2}; // -50
    vecs[2] = '{sw: 10'b0_0_1100_0010, exp_state: S_PLAY, hh: 1'b1, hl: 1'b0, inv: 1'b1, exp_count: 2}; // tens=12
    vecs[3] = '{sw: 10'b0_1_0011_0111, exp_state: S_WIN,  hh: 1'b0, hl: 1'b0, inv: 1'b0, exp_count: 3}; // -37

    Reset = 1'b0; Start_button = 1'b1; Guess_button = 1'b1;
    switch = '0; rdm_neg = 1'b0; rdm_tens = '0; rdm_ones = '0;
    m_state = S_IDLE; m_tgt = 0; m_count = 0; m_hh = 0; m_hl = 0; m_inv = 0;
    repeat (3) tick();
    check_reset_values("reset");
    Reset = 1'b1;
    tick();

    // Cycle-exact first press, target -37
    rdm_neg = 1'b1; rdm_tens = 4'd3; rdm_ones = 4'd7;
    Start_button = 1'b0;
    repeat (6) tick();
    chk("latency.idle", int'(state), S_IDLE);
    tick();
    chk("latency.arm", int'(state), S_ARM);
    tick();
    model_start(1'b1, 3, 7);
    check_model("first_start");
    repeat (2) tick();
    Start_button = 1'b1;
    repeat (10) tick();

    // Table-driven guesses against -37
    for (int i = 0; i < 4; i++) begin
      do_guess(vecs[i].sw, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_state", i), int'(state), vecs[i].exp_state);
      chk($sformatf("vec%0d.tbl_hh", i), int'(hint_high), int'(vecs[i].hh));
      chk($sformatf("vec%0d.tbl_hl", i), int'(hint_low), int'(vecs[i].hl));
      chk($sformatf("vec%0d.tbl_inv", i), int'(invalid), int'(vecs[i].inv));
      chk($sformatf("vec%0d.tbl_count", i), int'(count_tens) * 10 + int'(count_ones), vecs[i].exp_count);
    end

    // Guess press in WIN is ignored
    switch = 10'b0_0_0000_0001;
    Guess_button = 1'b0;
    repeat (10) tick();
    Guess_button = 1'b1;
    repeat (10) tick();
    check_model("win_hold");

    // Restart to +50, one wrong guess, then start+guess together
    do_start(1'b0, 5, 0, "start_p50");
    do_guess(10'b0_0_0000_0000, "guess_p00");
    switch = 10'b0_0_0101_0000;  // would win if the guess were taken
    Start_button = 1'b0; Guess_button = 1'b0;
    wait_state(S_ARM, 20, "both.arm");
    tick();
    model_start(1'b0, 5, 0);
    check_model("both");
    repeat (2) tick();
    Start_button = 1'b1; Guess_button = 1'b1;
    repeat (10) tick();
    check_model("both_after");

    // 2-cycle glitch on Guess_button
    Guess_button = 1'b0;
    repeat (2) tick();
    Guess_button = 1'b1;
    repeat (12) tick();
    check_model("glitch");

`ifdef GUESS_LIMIT_EN
    for (int i = 0; i < 3; i++) do_guess(10'b0_0_0000_0000, $sformatf("limit%0d", i));
    chk("limit.state", int'(state), S_LOSE);
    chk("limit.count", int'({count_tens, count_ones}), 8'h03);
`else
    for (int i = 0; i < 100; i++) do_guess(10'b0_0_0000_0000, $sformatf("sat%0d", i));
    chk("sat.state", int'(state), S_PLAY);
    chk("sat.count", int'({count_tens, count_ones}), 8'h99);
`endif

    // Randomized games against the model
    for (int game = 0; game < 6; game++) begin
      bit rn;
      int rt, ro;
      rn = 1'($urandom);
      rt = $urandom_range(0, 9);
      ro = $urandom_range(0, 9);
      if (game == 0) begin rn = 1'b1; rt = 0; ro = 0; end  // -0 target
      do_start(rn, rt, ro, $sformatf("rnd_start%0d", game));
      for (int g = 0; g < 10 && m_state == S_PLAY; g++) begin
        bit gn;
        int gt, go, mag;
        gn = 1'($urandom);
        gt = $urandom_range(0, 11);
        go = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        if ($urandom_range(0, 3) == 0) begin
          mag = (m_tgt < 0) ? -m_tgt : m_tgt;
          gt = mag / 10;
          go = mag % 10;
          gn = (m_tgt < 0) ? 1'b1 : ((mag == 0) ? 1'($urandom) : 1'b0);
        end
        do_guess({1'($urandom), gn, 4'(gt), 4'(go)}, $sformatf("rnd%0d_%0d", game, g));
      end
    end

    // Reset asserted while in CHECK
    do_start(1'b0, 4, 2, "pre_reset");
    switch = 10'b0_0_0001_0000;
    Guess_button = 1'b0;
    wait_state(S_CHECK, 20, "rst.check");
    Reset = 1'b0;
    #1;
    check_reset_values("rst_in_check");
    Guess_button = 1'b1;
    repeat (3) tick();
    Reset = 1'b1;
    repeat (10) tick();
    check_reset_values("rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
